// File: rtl/wb_master_sched_pkg.sv
// Shared definitions for the Wishbone grant scheduler and the bus mux.
//   sched_state_e : FSM state encodings (IDLE=0, BUSY=1, RELEASE=2)
//   MODE_RR/PRIO  : arbitration mode codes carried on i_mode
//   iw_for()      : width of a master index, max(1, clog2(nm))
package wb_master_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY    = 2'd1,
    ST_RELEASE = 2'd2
  } sched_state_e;

  localparam logic MODE_RR   = 1'b0;
  localparam logic MODE_PRIO = 1'b1;

  localparam int          BEATS_W   = 16;
  localparam logic [15:0] BEATS_MAX = 16'hFFFF;

  function automatic int iw_for(input int nm);
    return (nm > 1) ? $clog2(nm) : 1;
  endfunction

endpackage

// File: rtl/wb_rr_pick.sv
// Combinational request picker.
//   req      : per-master request (CYC) bits
//   last_idx : index of the most recently released master
//   mode     : MODE_RR rotates the search start to last_idx+1,
//              MODE_PRIO always searches from index 0
//   onehot   : one-hot winner (all zero when no request)
//   idx      : binary index of the winner (0 when no request)
//   any      : at least one request present
module wb_rr_pick
  import wb_master_sched_pkg::*;
#(
  parameter int NM = 2,
  parameter int IW = 1
) (
  input  logic [NM-1:0] req,
  input  logic [IW-1:0] last_idx,
  input  logic          mode,
  output logic [NM-1:0] onehot,
  output logic [IW-1:0] idx,
  output logic          any
);

  int   pos;
  logic found;

  // Walk NM candidate positions in search order; the first set bit wins.
  // In RR the walk starts one past last_idx and wraps, which needs at most
  // one subtraction because last_idx + 1 + k < 2*NM.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    pos   = 0;
    for (int k = 0; k < NM; k++) begin
      if (mode == MODE_PRIO) begin
        pos = k;
      end else begin
        pos = int'(last_idx) + 1 + k;
        if (pos >= NM) pos = pos - NM;
      end
      if (!found && req[pos[IW-1:0]]) begin
        found = 1'b1;
        idx   = pos[IW-1:0];
      end
    end
  end

  assign any    = |req;
  assign onehot = any ? (NM'(1) << idx) : '0;

endmodule

// File: rtl/wb_master_sched.sv
// Registered grant scheduler sharing one Wishbone slave-side bus among NM
// masters. Picks a requester in IDLE, holds the grant for the master's whole
// CYC, counts terminations and force-releases a master that sees no
// ack/err/rty for TIMEOUT cycles. Every grant ends with one RELEASE
// (turnaround) cycle, so two grants are separated by two o_gnt=0 cycles.
//
// Handshake: a grant is a level, not a pulse. o_gnt/o_gnt_idx are valid
// whenever o_gnt != 0; the owning master keeps it while its i_cyc bit stays
// high. A termination (ack|err|rty) is only meaningful while BUSY.
//
// Ports:
//   i_clk, i_rst : clock (rising edge), synchronous active-high reset
//   i_mode       : 0 round-robin, 1 fixed priority (sampled in IDLE only)
//   i_cyc[NM]    : per-master CYC request
//   i_ack/err/rty: slave terminations
//   o_gnt[NM]    : one-hot grant
//   o_gnt_idx    : index of the granted (or last granted) master
//   o_busy       : high in BUSY and RELEASE
//   o_timeout    : one-cycle pulse when the watchdog expires
//   o_beats      : terminations in the current grant, saturating
module wb_master_sched
  import wb_master_sched_pkg::*;
#(
  parameter  int NM      = 2,
  parameter  int TIMEOUT = 255,
  parameter  int TW      = 16,   // must be wide enough to hold TIMEOUT
  localparam int IW      = iw_for(NM)
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_mode,
  input  logic [NM-1:0]      i_cyc,
  input  logic               i_ack,
  input  logic               i_err,
  input  logic               i_rty,
  output logic [NM-1:0]      o_gnt,
  output logic [IW-1:0]      o_gnt_idx,
  output logic               o_busy,
  output logic               o_timeout,
  output logic [BEATS_W-1:0] o_beats
);

  sched_state_e       state_q, state_d;
  logic [NM-1:0]      gnt_q, gnt_d;
  logic [IW-1:0]      gnt_idx_q, gnt_idx_d;
  logic [IW-1:0]      last_idx_q, last_idx_d;
  logic               busy_q, busy_d;
  logic               timeout_q, timeout_d;
  logic [BEATS_W-1:0] beats_q, beats_d;
  logic [TW-1:0]      wd_q, wd_d;

  logic [NM-1:0] pick_onehot;
  logic [IW-1:0] pick_idx;
  logic          pick_any;
  logic          term;
  logic          own_cyc;
  logic          expire;

  wb_rr_pick #(
    .NM(NM),
    .IW(IW)
  ) u_pick (
    .req     (i_cyc),
    .last_idx(last_idx_q),
    .mode    (i_mode),
    .onehot  (pick_onehot),
    .idx     (pick_idx),
    .any     (pick_any)
  );

  assign term    = i_ack | i_err | i_rty;
  // The one-hot grant register masks out every non-owner request, so other
  // masters' CYC changes cannot influence the current grant.
  assign own_cyc = |(i_cyc & gnt_q);
  // A termination on the last watchdog cycle rescues the grant.
  assign expire  = !term && (wd_q == TW'(TIMEOUT - 1));

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    gnt_idx_d  = gnt_idx_q;
    last_idx_d = last_idx_q;
    busy_d     = busy_q;
    timeout_d  = 1'b0;
    beats_d    = beats_q;
    wd_d       = wd_q;
    unique case (state_q)
      ST_IDLE: begin
        gnt_d  = '0;
        busy_d = 1'b0;
        if (pick_any) begin
          gnt_d     = pick_onehot;
          gnt_idx_d = pick_idx;
          busy_d    = 1'b1;
          beats_d   = '0;
          wd_d      = '0;
          state_d   = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (term) begin
          if (beats_q != BEATS_MAX) beats_d = beats_q + 16'd1;
          wd_d = '0;
        end else begin
          wd_d = wd_q + TW'(1);
        end
        // A CYC drop takes precedence: the timeout only fires if the
        // owner is still requesting.
        if (!own_cyc || expire) begin
          gnt_d     = '0;
          timeout_d = own_cyc;
          state_d   = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        last_idx_d = gnt_idx_q;
        busy_d     = 1'b0;
        state_d    = ST_IDLE;
      end
      default: begin
        gnt_d   = '0;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= ST_IDLE;
      gnt_q      <= '0;
      gnt_idx_q  <= '0;
      last_idx_q <= IW'(NM - 1);
      busy_q     <= 1'b0;
      timeout_q  <= 1'b0;
      beats_q    <= '0;
      wd_q       <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      gnt_idx_q  <= gnt_idx_d;
      last_idx_q <= last_idx_d;
      busy_q     <= busy_d;
      timeout_q  <= timeout_d;
      beats_q    <= beats_d;
      wd_q       <= wd_d;
    end
  end

  assign o_gnt     = gnt_q;
  assign o_gnt_idx = gnt_idx_q;
  assign o_busy    = busy_q;
  assign o_timeout = timeout_q;
  assign o_beats   = beats_q;

endmodule

// File: tb/tb_wb_master_sched.sv
module tb_wb_master_sched;

  localparam int NM      = 2;
  localparam int TIMEOUT = 8;
  localparam int TW      = 16;
  localparam int IW      = 1;

  // ---------------- clock / reset ----------------
  logic i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  logic          i_rst;
  logic          i_mode;
  logic [NM-1:0] i_cyc;
  logic          i_ack, i_err, i_rty;
  logic [NM-1:0] o_gnt;
  logic [IW-1:0] o_gnt_idx;
  logic          o_busy, o_timeout;
  logic [15:0]   o_beats;

  wb_master_sched #(
    .NM(NM), .TIMEOUT(TIMEOUT), .TW(TW)
  ) dut (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_mode   (i_mode),
    .i_cyc    (i_cyc),
    .i_ack    (i_ack),
    .i_err    (i_err),
    .i_rty    (i_rty),
    .o_gnt    (o_gnt),
    .o_gnt_idx(o_gnt_idx),
    .o_busy   (o_busy),
    .o_timeout(o_timeout),
    .o_beats  (o_beats)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Tracks who owns the bus, whether the bus is in its turnaround cycle,
  // and how many cycles have passed without a termination.
  int m_owner = -1;
  int m_last  = NM - 1;
  int m_idx   = 0;
  int m_beats = 0;
  int m_quiet = 0;
  bit m_turn  = 1'b0;
  bit m_tmo   = 1'b0;
  bit started = 1'b0;

  function automatic int pick(input logic [NM-1:0] req, input bit prio, input int last);
    for (int k = 1; k <= NM; k++) begin
      int i;
      i = prio ? (k - 1) : ((last + k) % NM);
      if (((req >> i) & 1) != 0) return i;
    end
    return -1;
  endfunction

  always @(posedge i_clk) begin
    started = 1'b1;
    if (i_rst) begin
      m_owner = -1; m_last = NM - 1; m_idx = 0;
      m_beats = 0;  m_quiet = 0; m_turn = 1'b0; m_tmo = 1'b0;
    end else begin
      m_tmo = 1'b0;
      if (m_turn) begin
        m_turn = 1'b0;
      end else if (m_owner < 0) begin
        if (i_cyc != '0) begin
          m_owner = pick(i_cyc, i_mode, m_last);
          m_idx   = m_owner;
          m_beats = 0;
          m_quiet = 0;
        end
      end else begin
        bit t;
        t = i_ack | i_err | i_rty;
        if (t) begin
          if (m_beats < 65535) m_beats++;
          m_quiet = 0;
        end else begin
          m_quiet++;
        end
        if (((i_cyc >> m_owner) & 1) == 0) begin
          m_last = m_owner; m_owner = -1; m_turn = 1'b1;
        end else if (!t && m_quiet == TIMEOUT) begin
          m_tmo = 1'b1; m_last = m_owner; m_owner = -1; m_turn = 1'b1;
        end
      end
    end
  end

  // Compare every cycle, away from the active edge.
  always @(negedge i_clk) begin
    if (started) begin
      chk("gnt",     32'(o_gnt),     (m_owner >= 0) ? 32'(1 << m_owner) : 32'd0);
      chk("gnt_idx", 32'(o_gnt_idx), 32'(m_idx));
      chk("busy",    32'(o_busy),    32'((m_owner >= 0) || m_turn));
      chk("timeout", 32'(o_timeout), 32'(m_tmo));
      chk("beats",   32'(o_beats),   32'(m_beats));
    end
  end

  // ---------------- grant-order scoreboard ----------------
  logic [NM-1:0] exp_q[$];
  logic [NM-1:0] prev_gnt = '0;

  always @(negedge i_clk) begin
    if (o_gnt != '0 && prev_gnt == '0) begin
      if (exp_q.size() == 0) begin
        chk("grant_unexpected", 32'(o_gnt), 32'd0);
      end else begin
        chk("grant_order", 32'(o_gnt), 32'(exp_q.pop_front()));
      end
    end
    prev_gnt = o_gnt;
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge i_clk);
  endtask

  // Owner takes nacks acks, drops CYC, re-requests during turnaround.
  task automatic serve(input int idx, input int nacks, input logic [NM-1:0] next_gnt);
    i_ack = 1'b1;
    tick(nacks);
    i_ack = 1'b0;
    i_cyc[idx] = 1'b0;
    tick(1);
    chk("beats_at_release", 32'(o_beats), 32'(nacks));
    chk("gnt_in_release",   32'(o_gnt),   32'd0);
    chk("busy_in_release",  32'(o_busy),  32'd1);
    i_cyc[idx] = 1'b1;
    exp_q.push_back(next_gnt);
    tick(1);
    chk("gnt_in_idle", 32'(o_gnt), 32'd0);
    tick(1);
    chk("regrant", 32'(o_gnt), 32'(next_gnt));
  endtask

  initial begin
    #200000;
    $display("FAIL global_time_limit: got no finish expected finish");
    $fatal(1);
  end

  // ---------------- directed stimulus ----------------
  initial begin
    i_rst = 1'b1; i_mode = 1'b0; i_cyc = 2'b11;
    i_ack = 1'b0; i_err = 1'b0; i_rty = 1'b0;

    // 1: reset with both masters requesting
    tick(3);
    chk("rst_gnt",   32'(o_gnt),   32'd0);
    chk("rst_busy",  32'(o_busy),  32'd0);
    chk("rst_beats", 32'(o_beats), 32'd0);
    exp_q.push_back(2'b01);
    i_rst = 1'b0;
    tick(1);
    chk("first_grant", 32'(o_gnt), 32'h1);

    // 2: round-robin alternation with 4 acks per grant
    serve(0, 4, 2'b10);
    serve(1, 4, 2'b01);

    // 3: fixed priority, switched mid-grant; master 0 keeps winning
    i_mode = 1'b1;
    serve(0, 2, 2'b01);
    chk("prio_idx_a", 32'(o_gnt_idx), 32'd0);
    serve(0, 2, 2'b01);
    chk("prio_idx_b", 32'(o_gnt_idx), 32'd0);

    // 4: watchdog on master 1 with no termination
    i_mode = 1'b0;
    i_cyc  = 2'b10;
    exp_q.push_back(2'b10);
    tick(3);
    chk("wd_grant", 32'(o_gnt), 32'h2);
    tick(7);
    chk("wd_not_yet", 32'(o_timeout), 32'd0);
    tick(1);
    chk("wd_pulse",     32'(o_timeout), 32'd1);
    chk("wd_gnt_freed", 32'(o_gnt),     32'd0);
    exp_q.push_back(2'b10);
    tick(1);
    chk("wd_pulse_end", 32'(o_timeout), 32'd0);
    tick(1);

    // 5: ack on the expiry cycle rescues the grant
    tick(7);
    i_ack = 1'b1;
    tick(1);
    i_ack = 1'b0;
    chk("rescue_no_timeout", 32'(o_timeout), 32'd0);
    chk("rescue_beats",      32'(o_beats),   32'd1);
    chk("rescue_gnt",        32'(o_gnt),     32'h2);

    // 6: reset mid-burst while master 0 owns the bus
    i_cyc = 2'b01;
    exp_q.push_back(2'b01);
    tick(3);
    i_cyc = 2'b11;
    i_ack = 1'b1;
    tick(3);
    i_ack = 1'b0;
    chk("pre_reset_beats", 32'(o_beats), 32'd3);
    i_rst = 1'b1;
    exp_q.push_back(2'b01);
    tick(1);
    chk("midrst_gnt",   32'(o_gnt),   32'd0);
    chk("midrst_beats", 32'(o_beats), 32'd0);
    chk("midrst_busy",  32'(o_busy),  32'd0);
    i_rst = 1'b0;
    tick(1);
    chk("rr_restart", 32'(o_gnt), 32'h1);

    // err and rty count as beats too
    i_err = 1'b1; tick(1); i_err = 1'b0;
    i_rty = 1'b1; tick(1); i_rty = 1'b0;
    chk("err_rty_beats", 32'(o_beats), 32'd2);

    // CYC drop on the expiry cycle: drop wins, no timeout
    tick(7);
    i_cyc = 2'b00;
    tick(1);
    chk("drop_vs_expiry_tmo", 32'(o_timeout), 32'd0);
    chk("drop_vs_expiry_gnt", 32'(o_gnt),     32'd0);

    // terminations while idle are ignored
    tick(2);
    i_ack = 1'b1;
    tick(3);
    i_ack = 1'b0;
    chk("idle_ack_beats", 32'(o_beats), 32'd2);
    chk("idle_busy",      32'(o_busy),  32'd0);
    tick(2);

    chk("grant_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
